// File: rtl/key_event.sv
// key_event
// Classifies clean single-key presses on four debounced, active-low key
// levels as short or long, measured from press to release. Events go into a
// first-word-fall-through FIFO and are handed out over a valid/ready
// handshake. Chords and key swaps are discarded until all keys are released.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_lvl    debounced key levels, active-low (1 = released)
//   evt_valid  FIFO non-empty, head event presented
//   evt_ready  consumer accepts head event when evt_valid=1
//   evt_key    head event key index (bit of key_lvl)
//   evt_long   head event is a long press
//   evt_ovf    sticky: an event was dropped on a full FIFO
//   busy       a valid single-key press is being timed
//
// state    | meaning
// IDLE     | all keys released, waiting for a press
// HELD     | exactly one key down, hold length being counted
// WAIT_REL | chord/swap seen (or just out of reset), wait for all released
module key_event #(
  parameter int LONG_CYC = 12_000_000,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_lvl,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_long,
  output logic       evt_ovf,
  output logic       busy
);

  localparam int CW = $clog2(LONG_CYC + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYC);

  typedef enum logic [1:0] {IDLE, HELD, WAIT_REL} state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    key_q, key_nxt;
  logic          push;
  logic          single_low;
  logic [1:0]    single_idx;
  logic [3:0]    held_pat;

  always_comb begin
    single_low = 1'b1;
    single_idx = 2'd0;
    case (key_lvl)
      4'b1110: single_idx = 2'd0;
      4'b1101: single_idx = 2'd1;
      4'b1011: single_idx = 2'd2;
      4'b0111: single_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  assign held_pat = ~(4'b0001 << key_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      key_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      key_q   <= key_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    key_nxt   = key_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_lvl != 4'hF) begin
          if (single_low) begin
            key_nxt   = single_idx;
            cnt_nxt   = CW'(1);
            state_nxt = HELD;
          end else begin
            state_nxt = WAIT_REL;
          end
        end
      end
      HELD: begin
        if (key_lvl == held_pat) begin
          // saturate so very long holds cannot wrap back to "short"
          if (cnt_q < LONG_TC) cnt_nxt = cnt_q + CW'(1);
        end else if (key_lvl == 4'hF) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (key_lvl == 4'hF) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_REL;
    endcase
  end

  assign busy = (state_q == HELD);

  // event FIFO: entry = {long, key}; pointers carry an extra wrap bit
  logic [2:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, do_push;
  logic [2:0]  push_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = evt_valid && evt_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push   = push && (!full || pop);
  assign push_data = {(cnt_q >= LONG_TC), key_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)     rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (push && full && !pop) evt_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign evt_valid = !empty;
  assign evt_key   = mem[rd_ptr[AW-1:0]][1:0];
  assign evt_long  = mem[rd_ptr[AW-1:0]][2];

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic       evt_long;
  logic       evt_ovf;
  logic       busy;

  int tests = 0;
  int fails = 0;

  key_event #(.LONG_CYC(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .key_lvl(key_lvl),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_key(evt_key), .evt_long(evt_long),
    .evt_ovf(evt_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance n rising edges; outputs are then observed 1 time unit later
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_lvl = 4'hF; evt_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    tests++; if (evt_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", evt_ovf); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tick(1);
  endtask

  task automatic test_short();
    int busy_cnt;
    busy_cnt = 0;
    key_lvl = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (busy === 1'b1) busy_cnt++;
    end
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL short_early_valid got %b want 0", evt_valid); end
    key_lvl = 4'hF;
    tick(1);
    if (busy === 1'b1) busy_cnt++;
    tests++; if (busy_cnt != 3) begin fails++; $display("FAIL short_busy_cycles got %0d want 3", busy_cnt); end
    tests++; if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_long !== 1'b0) begin
      fails++; $display("FAIL short_event got v=%b k=%0d l=%b want v=1 k=0 l=0", evt_valid, evt_key, evt_long);
    end
    tick(1);
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL short_popped got %b want 0", evt_valid); end
  endtask

  task automatic press_check(input string nm, input logic [3:0] pat, input int n,
                             input logic [1:0] ek, input logic el);
    key_lvl = pat;
    tick(n);
    key_lvl = 4'hF;
    tick(1);
    tests++; if (evt_valid !== 1'b1 || evt_key !== ek || evt_long !== el) begin
      fails++; $display("FAIL %s got v=%b k=%0d l=%b want v=1 k=%0d l=%b", nm, evt_valid, evt_key, evt_long, ek, el);
    end
    tick(1);
  endtask

  task automatic test_long();
    press_check("long_8", 4'b0111, 8, 2'd3, 1'b1);
    press_check("short_7", 4'b0111, 7, 2'd3, 1'b0);
    press_check("long_sat_40", 4'b0111, 40, 2'd3, 1'b1);
  endtask

  task automatic test_chord();
    int bad;
    bad = 0;
    key_lvl = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (busy !== 1'b0 || evt_valid !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL chord_quiet got %0d bad cycles want 0", bad); end
    key_lvl = 4'hF;
    tick(1);
    press_check("chord_then_key1", 4'b1101, 2, 2'd1, 1'b0);
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL chord_single_event got %b want 0", evt_valid); end
  endtask

  task automatic test_swap();
    key_lvl = 4'b1110; tick(3);
    key_lvl = 4'b1010; tick(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL swap_busy got %b want 0", busy); end
    key_lvl = 4'b1110; tick(1);
    key_lvl = 4'hF;    tick(2);
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL swap_no_event got %b want 0", evt_valid); end
    press_check("after_swap_key2", 4'b1011, 2, 2'd2, 1'b0);
  endtask

  task automatic test_overflow();
    logic [1:0] keys [5];
    logic [1:0] drain [4];
    keys = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_lvl = ~(4'b0001 << keys[i]);
      tick(2);
      key_lvl = 4'hF;
      tick(1);
      if (i == 3) begin
        tests++; if (evt_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", evt_ovf); end
      end
    end
    tests++; if (evt_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", evt_ovf); end
    tests++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      fails++; $display("FAIL ovf_head_stable got v=%b k=%0d want v=1 k=0", evt_valid, evt_key);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (evt_valid !== 1'b1 || evt_key !== keys[i]) begin
        fails++; $display("FAIL drain_%0d got v=%b k=%0d want v=1 k=%0d", i, evt_valid, evt_key, keys[i]);
      end
      tick(1);
    end
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", evt_valid); end

    // refill to full, then release a press on the same edge as a pop
    evt_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      key_lvl = ~(4'b0001 << k[1:0]);
      tick(2);
      key_lvl = 4'hF;
      tick(1);
    end
    key_lvl = 4'b1011;
    tick(2);
    key_lvl = 4'hF;
    evt_ready = 1'b1;
    tick(1);
    drain = '{2'd2, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      tests++; if (evt_valid !== 1'b1 || evt_key !== drain[i]) begin
        fails++; $display("FAIL pushpop_full_%0d got v=%b k=%0d want v=1 k=%0d", i, evt_valid, evt_key, drain[i]);
      end
      tick(1);
    end
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL pushpop_empty got %b want 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      key_lvl = ~(4'b0001 << k[1:0]);
      tick(2);
      key_lvl = 4'hF;
      tick(1);
    end
    key_lvl = 4'b1110;
    tick(2);
    tests++; if (busy !== 1'b1 || evt_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got busy=%b v=%b want busy=1 v=1", busy, evt_valid);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tests++; if (evt_valid !== 1'b0 || evt_ovf !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset got v=%b ovf=%b busy=%b want 0 0 0", evt_valid, evt_ovf, busy);
    end
    tick(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_held_busy got %b want 0", busy); end
    key_lvl = 4'hF;
    tick(2);
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL mid_release_event got %b want 0", evt_valid); end
    evt_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; key_lvl = 4'hF; evt_ready = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_chord();
    test_swap();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event.md
# key_event

Key event encoder downstream of the debounced key inputs. It consumes the four debounced, active-low key levels and classifies each clean single-key press as short or long, measured from the press to its release. Events are queued in a small first-word-fall-through FIFO. Each event is handed to the mode/LED control logic over a valid/ready handshake. Multi-key chords are rejected, matching the key block's "invalid input" condition.

## Interface
Parameters:
- LONG_CYC, 12_000_000: minimum hold length in clk cycles for a long press (1 s at 12 MHz)
- DEPTH, 4: event FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  reset; synchronous, active-high
- key_lvl  in  4  debounced key levels, active-low (1 = released)
- evt_valid  out  1  FIFO non-empty; head event presented
- evt_ready  in  1  consumer accepts head event when evt_valid=1
- evt_key  out  2  head event key index 0..3 (bit i of key_lvl)
- evt_long  out  1  head event is a long press
- evt_ovf  out  1  sticky: an event was dropped because the FIFO was full
- busy  out  1  high while a valid single-key press is being timed (state HELD)

## Operation
- All inputs are sampled on the rising edge of clk. key_lvl is already synchronous; no further debounce is applied.
- FSM states: IDLE, HELD, WAIT_REL.
- IDLE:
  - key_lvl=4'hF: stay.
  - Exactly one bit low: capture its index, cnt<=1, go to HELD.
  - Two or more bits low: go to WAIT_REL. No event.
- HELD:
  - key_lvl equals the captured key alone low: cnt<=cnt+1, saturating at LONG_CYC.
  - key_lvl=4'hF: push {key, long = (cnt>=LONG_CYC)}, go to IDLE.
  - Any other pattern (second key pressed, or a key swap): discard, go to WAIT_REL.
- WAIT_REL: stay until key_lvl=4'hF is sampled, then go to IDLE. No event.
- Hold length equals the number of edges sampling the key low. The event is long iff hold length ≥ LONG_CYC.
- cnt width is $clog2(LONG_CYC+1).
- FIFO:
  - 3-bit entries, DEPTH deep, circular pointers carrying an extra wrap bit.
  - Pop on evt_valid && evt_ready.
  - Push when full with no pop: the event is dropped and evt_ovf<=1.
  - Push and pop in the same cycle while full: both happen, nothing is dropped.
  - Push and pop in the same cycle while empty: impossible, since evt_valid=0.
- evt_ovf clears only on rst.
- evt_key and evt_long reflect the head entry. They are don't-care while evt_valid=0 and must hold stable while evt_valid=1 and evt_ready=0.

## Timing
- Reset values, registered at the first edge with rst=1:
  - state=WAIT_REL, so a key held through reset never produces an event.
  - FIFO empty, evt_valid=0, evt_ovf=0, busy=0, cnt=0.
- rst=1 mid-operation: any press in progress and all queued events are discarded at that edge.
- Press sampled at edge P: busy=1 after P.
- Release sampled at edge R:
  - The push occurs at R, and busy=0 after R.
  - evt_valid=1 after R if the FIFO was empty. Event latency is 1 cycle from the release sample.
- Pop at edge E: the next entry is presented after E. Back-to-back pops are possible every cycle.
- A new press may be captured at edge R+1, i.e. the first IDLE edge.

## Test plan
Bench parameters: LONG_CYC=8, DEPTH=4, evt_ready=1 unless noted.
- Reset with key_lvl=4'hF, then key_lvl=4'b1110 for 3 cycles, then 4'hF → one event key=0, long=0; evt_valid high exactly 1 cycle after the release edge; busy high for 3 cycles.
- key_lvl=4'b0111 for 8 cycles, release → key=3, long=1. Same for 7 cycles → key=3, long=0. Same for 40 cycles → long=1 (counter saturates, no wrap).
- key_lvl=4'b1100 for 5 cycles, then 4'hF, then 4'b1101 for 2 cycles, then 4'hF → exactly one event: key=1, long=0; busy stays 0 during the chord.
- 4'b1110 for 3 cycles, then 4'b1010, then 4'b1110, then 4'hF → no event; a following 4'b1011 short press → key=2.
- evt_ready=0, short presses on keys 0,1,2,3,0 → evt_ovf=1 after the 5th release. Then evt_ready=1 → events 0,1,2,3 in order, evt_valid=0 after the 4th pop. Next: full FIFO with a simultaneous release and pop → no further drop.
- Hold 4'b1110, queue 2 events, assert rst for 1 cycle while the key is still held → evt_valid=0, evt_ovf=0, busy=0; releasing the key → no event.
